magb_sample_assembler: RTL and testbench

Downstream consumer of the MAGB I2C/APB control stage. It takes the bytes read back from the magnetometer, one `rx_valid` strobe per byte, and assembles each group of six into a signed X/Y/Z sample. Completed samples go into a small show-ahead FIFO for the telemetry/housekeeping logic. The block also flags stalled or aborted frames and saturated readings, and keeps drop/abort statistics.

---
 rtl/magb_pkg.sv | 58 +++++
 rtl/magb_sample_fifo.sv | 94 +++++++++
 rtl/magb_sample_assembler.sv | 193 +++++++++++++++++++
 tb/tb_magb_sample_assembler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/magb_pkg.sv
// Shared types and constants for the MAGB sample assembler and its FIFO.
package magb_pkg;

  // Assembler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Width of one assembled {X, Y, Z} sample.
  localparam int SAMPLE_W = 48;

  // Byte positions within a frame, in arrival order.
  localparam logic [2:0] IDX_X_H = 3'd0;
  localparam logic [2:0] IDX_X_L = 3'd1;
  localparam logic [2:0] IDX_Y_H = 3'd2;
  localparam logic [2:0] IDX_Y_L = 3'd3;
  localparam logic [2:0] IDX_Z_H = 3'd4;
  localparam logic [2:0] IDX_Z_L = 3'd5;

  // Full-scale readings reported by the sensor when an axis saturates.
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Place one received byte into its slot of the sample word (X_H is the MSB).
  function automatic logic [SAMPLE_W-1:0] put_byte(input logic [SAMPLE_W-1:0] word,
                                                    input logic [2:0] idx,
                                                    input logic [7:0] data);
    logic [SAMPLE_W-1:0] res;
    res = word;
    case (idx)
      IDX_X_H: res[47:40] = data;
      IDX_X_L: res[39:32] = data;
      IDX_Y_H: res[31:24] = data;
      IDX_Y_L: res[23:16] = data;
      IDX_Z_H: res[15:8]  = data;
      IDX_Z_L: res[7:0]   = data;
      default: res = word;
    endcase
    return res;
  endfunction

  // True when any axis of the sample sits at positive or negative full scale.
  function automatic logic is_sat_sample(input logic [SAMPLE_W-1:0] word);
    logic hit;
    hit = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if ((word[a*16 +: 16] == SAT_POS) || (word[a*16 +: 16] == SAT_NEG)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/magb_sample_fifo.sv
// Show-ahead synchronous FIFO. The head entry is held in a register so that
// rd_data is a flop output; it holds its last value once the FIFO drains.
module magb_sample_fifo
  import magb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] head_r;
  logic             empty_r;
  logic             full_r;

  logic             rd_go_s;
  logic             wr_go_s;
  logic [LW-1:0]    level_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Qualify requests, compute next occupancy and the entry presented after this edge.
  always_comb begin
    rd_go_s      = rd_en && !empty_r;
    wr_go_s      = wr_en && (!full_r || rd_go_s);
    level_next_s = level_r;
    head_next_s  = head_r;
    case ({wr_go_s, rd_go_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
    if (rd_go_s) begin
      if (level_r > LW'(1)) begin
        head_next_s = mem_r[rd_ptr_r + AW'(1)];
      end else if (wr_go_s) begin
        head_next_s = wr_data;
      end else begin
        head_next_s = head_r;
      end
    end else if (wr_go_s && empty_r) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage, pointers, occupancy and registered status flags.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_go_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_go_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      head_r  <= head_next_s;
      empty_r <= (level_next_s == {LW{1'b0}});
      full_r  <= (level_next_s == LW'(DEPTH));
    end
  end

  assign rd_data = head_r;
  assign empty   = empty_r;
  assign full    = full_r;
  assign level   = level_r;

endmodule

// File: rtl/magb_sample_assembler.sv
// Assembles six magnetometer bytes into a signed {X,Y,Z} sample, queues it in a
// show-ahead FIFO and tracks aborted frames, overflow drops and saturation.
module magb_sample_assembler
  import magb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          frame_start,
  input  logic                          rd_en,
  input  logic                          clr_stats,
  output logic [SAMPLE_W-1:0]           rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          sat_flag,
  output logic [CNT_W-1:0]              drop_count,
  output logic [CNT_W-1:0]              abort_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_r, state_next_s;
  logic [2:0]          idx_r, idx_next_s;
  logic [SAMPLE_W-1:0] shift_r, shift_next_s;
  logic [TW-1:0]       tmo_r, tmo_next_s;
  logic                abort_s;
  logic                commit_s;
  logic                drop_s;
  logic                sat_s;
  logic                full_s;

  logic                sat_r;
  logic [CNT_W-1:0]    drop_r;
  logic [CNT_W-1:0]    abort_r;

  // Next-state, byte placement, inter-byte timeout and abort/commit decode.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    tmo_next_s   = {TW{1'b0}};
    abort_s      = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          shift_next_s = put_byte(shift_r, IDX_X_H, rx_data);
          idx_next_s   = IDX_X_L;
          state_next_s = ST_COLLECT;
        end else begin
          idx_next_s   = IDX_X_H;
          state_next_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (frame_start) begin
          // A new transaction kills the partial frame; a coincident byte opens the new one.
          abort_s = 1'b1;
          if (rx_valid) begin
            shift_next_s = put_byte(shift_r, IDX_X_H, rx_data);
            idx_next_s   = IDX_X_L;
            state_next_s = ST_COLLECT;
          end else begin
            idx_next_s   = IDX_X_H;
            state_next_s = ST_IDLE;
          end
        end else if (rx_valid) begin
          shift_next_s = put_byte(shift_r, idx_r, rx_data);
          if (idx_r == IDX_Z_L) begin
            idx_next_s   = IDX_X_H;
            state_next_s = ST_COMMIT;
          end else begin
            idx_next_s   = idx_r + 3'd1;
            state_next_s = ST_COLLECT;
          end
        end else if (tmo_r == TMO_LAST) begin
          abort_s      = 1'b1;
          idx_next_s   = IDX_X_H;
          state_next_s = ST_IDLE;
        end else begin
          tmo_next_s   = tmo_r + TW'(1);
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        if (rx_valid) begin
          shift_next_s = put_byte(shift_r, IDX_X_H, rx_data);
          idx_next_s   = IDX_X_L;
          state_next_s = ST_COLLECT;
        end else begin
          idx_next_s   = IDX_X_H;
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        idx_next_s   = IDX_X_H;
        state_next_s = ST_IDLE;
      end
    endcase
    drop_s = commit_s && full_s && !rd_en;
    sat_s  = commit_s && is_sat_sample(shift_r);
  end

  // FSM state, byte index, assembly register and timeout counter.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_X_H;
      shift_r <= {SAMPLE_W{1'b0}};
      tmo_r   <= {TW{1'b0}};
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      shift_r <= shift_next_s;
      tmo_r   <= tmo_next_s;
    end
  end

  // Sticky saturation flag and saturating statistics; a set event beats a clear.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sat_r   <= 1'b0;
      drop_r  <= {CNT_W{1'b0}};
      abort_r <= {CNT_W{1'b0}};
    end else begin
      if (sat_s) begin
        sat_r <= 1'b1;
      end else if (clr_stats) begin
        sat_r <= 1'b0;
      end else begin
        sat_r <= sat_r;
      end

      if (drop_s) begin
        if (clr_stats) begin
          drop_r <= CNT_ONE;
        end else if (drop_r != CNT_MAX) begin
          drop_r <= drop_r + CNT_ONE;
        end else begin
          drop_r <= drop_r;
        end
      end else if (clr_stats) begin
        drop_r <= {CNT_W{1'b0}};
      end else begin
        drop_r <= drop_r;
      end

      if (abort_s) begin
        if (clr_stats) begin
          abort_r <= CNT_ONE;
        end else if (abort_r != CNT_MAX) begin
          abort_r <= abort_r + CNT_ONE;
        end else begin
          abort_r <= abort_r;
        end
      end else if (clr_stats) begin
        abort_r <= {CNT_W{1'b0}};
      end else begin
        abort_r <= abort_r;
      end
    end
  end

  magb_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .wr_en   (commit_s),
    .wr_data (shift_r),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full_s),
    .level   (level)
  );

  assign full        = full_s;
  assign sat_flag    = sat_r;
  assign drop_count  = drop_r;
  assign abort_count = abort_r;

endmodule

// File: tb/tb_magb_sample_assembler.sv
// Directed, table-driven bench for magb_sample_assembler.
module tb_magb_sample_assembler;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;
  localparam int CW    = 8;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_start;
  logic        rd_en;
  logic        clr_stats;
  logic [47:0] rd_data;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        sat_flag;
  logic [7:0]  drop_count;
  logic [7:0]  abort_count;

  int n_checks = 0;
  int n_fail   = 0;

  magb_sample_assembler #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .clr_stats   (clr_stats),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .sat_flag    (sat_flag),
    .drop_count  (drop_count),
    .abort_count (abort_count)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [47:0] frame;
    logic [47:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) begin
      send_byte(f[47-8*i -: 8]);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic clear();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_rd_data", rd_data, 48'h0);
    chk("rst_empty", {47'd0, empty}, 48'd1);
    chk("rst_full", {47'd0, full}, 48'd0);
    chk("rst_level", {45'd0, level}, 48'd0);
    chk("rst_sat", {47'd0, sat_flag}, 48'd0);
    chk("rst_drop", {40'd0, drop_count}, 48'd0);
    chk("rst_abort", {40'd0, abort_count}, 48'd0);
  endtask

  function automatic logic [47:0] ovf_frame(input int n);
    logic [7:0] base;
    base = 8'(n * 16);
    return {base, base + 8'd1, base + 8'd2, base + 8'd3, base + 8'd4, base + 8'd5};
  endfunction

  initial begin
    vecs[0] = '{48'h12_34_FF_FE_80_01, 48'h1234_FFFE_8001, 1'b0};
    vecs[1] = '{48'h7F_FF_00_00_00_00, 48'h7FFF_0000_0000, 1'b1};
    vecs[2] = '{48'h00_00_80_00_00_01, 48'h0000_8000_0001, 1'b1};
    vecs[3] = '{48'h00_01_00_02_7F_FF, 48'h0001_0002_7FFF, 1'b1};
    vecs[4] = '{48'h7F_FE_80_01_FF_FF, 48'h7FFE_8001_FFFF, 1'b0};
    vecs[5] = '{48'hA5_5A_0F_F0_C3_3C, 48'hA55A_0FF0_C33C, 1'b0};

    PRESETN = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; frame_start = 1'b0;
    rd_en = 1'b0; clr_stats = 1'b0;
    step(); step();
    chk_reset_values();
    PRESETN = 1'b1;
    step();

    // Table: one frame at a time, sample visible two cycles after the last byte.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].frame);
      step();
      chk($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_level", v), {45'd0, level}, 48'd1);
      chk($sformatf("vec%0d_sat", v), {47'd0, sat_flag}, {47'd0, vecs[v].exp_sat});
      rd_en = 1'b1; clr_stats = 1'b1;
      step();
      rd_en = 1'b0; clr_stats = 1'b0;
      chk($sformatf("vec%0d_empty", v), {47'd0, empty}, 48'd1);
      chk($sformatf("vec%0d_clr_sat", v), {47'd0, sat_flag}, 48'd0);
    end

    // Sticky saturation, clear, and set beating a coincident clear.
    send_frame(48'h7F_FF_00_00_00_00);
    step();
    chk("sat_set", {47'd0, sat_flag}, 48'd1);
    pop();
    send_frame(48'h01_02_03_04_05_06);
    step();
    chk("sat_sticky", {47'd0, sat_flag}, 48'd1);
    pop();
    clear();
    chk("sat_cleared", {47'd0, sat_flag}, 48'd0);
    send_frame(48'h00_00_80_00_00_00);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("sat_set_wins", {47'd0, sat_flag}, 48'd1);
    pop();
    clear();

    // Abort: frame_start coincident with a byte restarts the frame at that byte.
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    frame_start = 1'b1;
    send_byte(8'hAA);
    frame_start = 1'b0;
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE); send_byte(8'h11);
    step();
    chk("abort_data", rd_data, 48'hAABB_CCDD_EE11);
    chk("abort_level", {45'd0, level}, 48'd1);
    chk("abort_count", {40'd0, abort_count}, 48'd1);
    pop();
    clear();

    // Timeout: fires exactly after TMO idle cycles inside a frame.
    send_byte(8'h21); send_byte(8'h22);
    repeat (TMO - 1) step();
    chk("tmo_not_yet", {40'd0, abort_count}, 48'd0);
    step();
    chk("tmo_abort", {40'd0, abort_count}, 48'd1);
    chk("tmo_no_push", {45'd0, level}, 48'd0);
    send_frame(48'h31_32_33_34_35_36);
    rd_en = 1'b1;  // pop with push on an empty FIFO: push only
    step();
    rd_en = 1'b0;
    chk("tmo_next_data", rd_data, 48'h3132_3334_3536);
    chk("tmo_push_pop_empty", {45'd0, level}, 48'd1);
    pop();
    clear();

    // Overflow: five back-to-back frames into a depth-4 FIFO.
    for (int n = 1; n <= 5; n++) send_frame(ovf_frame(n));
    step();
    chk("ovf_full", {47'd0, full}, 48'd1);
    chk("ovf_level", {45'd0, level}, 48'd4);
    chk("ovf_drop", {40'd0, drop_count}, 48'd1);
    chk("ovf_head", rd_data, 48'h1011_1213_1415);
    send_frame(ovf_frame(6));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ovf_pushpop_drop", {40'd0, drop_count}, 48'd1);
    chk("ovf_pushpop_full", {47'd0, full}, 48'd1);
    chk("ovf_head2", rd_data, 48'h2021_2223_2425);
    chk("drain0", rd_data, 48'h2021_2223_2425); pop();
    chk("drain1", rd_data, 48'h3031_3233_3435); pop();
    chk("drain2", rd_data, 48'h4041_4243_4445); pop();
    chk("drain3", rd_data, 48'h6061_6263_6465); pop();
    chk("drain_empty", {47'd0, empty}, 48'd1);
    pop();
    chk("pop_empty_level", {45'd0, level}, 48'd0);
    chk("pop_empty_hold", rd_data, 48'h6061_6263_6465);
    clear();

    // Abort counter saturates at 255.
    repeat (260) begin
      send_byte(8'h55);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    chk("abort_sat", {40'd0, abort_count}, 48'd255);
    clear();
    chk("abort_clr", {40'd0, abort_count}, 48'd0);

    // Reset mid-frame with a queued saturating sample.
    send_frame(48'h7F_FF_00_00_00_00);
    step();
    chk("pre_rst_level", {45'd0, level}, 48'd1);
    send_byte(8'h91); send_byte(8'h92); send_byte(8'h93); send_byte(8'h94);
    PRESETN = 1'b0;
    #1;
    chk_reset_values();
    step();
    PRESETN = 1'b1;
    step();
    send_frame(48'h41_42_43_44_45_46);
    step();
    chk("post_rst_data", rd_data, 48'h4142_4344_4546);
    chk("post_rst_level", {45'd0, level}, 48'd1);
    pop();
    chk("post_rst_empty", {47'd0, empty}, 48'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
